md_stall_ctrl: RTL and testbench
================================

// Module: md_stall_ctrl
// PURPOSE
//  Pipeline hazard/stall controller that also sequences the multi-cycle HI/LO mult/div unit.
//  - Detects hazards that the bypass network cannot cover: load-use, and branch/jr/jalr operands in ID.
//  - Tracks mult/div occupancy with a countdown FSM.
//  - Drives PC hold, IF/ID hold and ID/EX bubble insertion.
//  - Keeps a saturating stall-cycle performance counter.
//  Sits beside the forwarding unit in the control path.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu; must satisfy 1..2^CNT_W
//  DIV_CYCLES   10  busy cycles for div/divu; must satisfy 1..2^CNT_W
//  CNT_W        4   width of the busy countdown counter
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst_n          in   1   synchronous reset, active-low
//  md_start_id_ex in   1   mult/div instruction valid in EX this cycle
//  md_is_div      in   1   qualifies md_start_id_ex: 1 = div/divu, 0 = mult/multu
//  md_use_if_id   in   1   ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//  Branch         in   1   ID instruction is a branch (compared in ID)
//  jr             in   1   ID instruction is jr
//  jalr           in   1   ID instruction is jalr
//  use_rs_id      in   1   ID instruction reads rs
//  use_rt_id      in   1   ID instruction reads rt
//  rs_if_id       in   5   ID rs field
//  rt_if_id       in   5   ID rt field
//  RegWrite_id_ex in   1   EX instruction writes the register file
//  MemRead_id_ex  in   1   EX instruction is a load
//  WReg_id_ex     in   5   EX destination register
//  MemRead_ex_mem in   1   MEM instruction is a load
//  WReg_ex_mem    in   5   MEM destination register
//  stall_if       out  1   hold PC
//  stall_id       out  1   hold the IF/ID register
//  bubble_ex      out  1   load a NOP into ID/EX
//  md_start       out  1   one-cycle start pulse to the HI/LO unit
//  md_busy        out  1   mult/div unit occupied
//  md_done        out  1   asserted in the final busy cycle
//  md_cnt         out  CNT_W  busy cycles remaining minus 1
//  stall_cycles   out  32  count of cycles with stall=1; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, md_cnt=0, stall_cycles=0.
//   - Resulting outputs: md_busy=0, md_done=0, md_start=0.
//   - Reset during BUSY abandons the operation; no md_done is issued.
//  FSM states: IDLE, BUSY.
//   - md_start = md_start_id_ex & (state==IDLE). Combinational, same cycle.
//   - IDLE -> BUSY on md_start. md_cnt loads DIV_CYCLES-1 if md_is_div, else MULT_CYCLES-1.
//   - BUSY with md_cnt!=0: md_cnt decrements by 1.
//   - BUSY with md_cnt==0: md_done=1 and next state is IDLE.
//   - md_busy = (state==BUSY). It is high for exactly N cycles, starting the cycle after md_start.
//   - md_start_id_ex while BUSY cannot occur, because md_use stalls keep mult/div out of EX.
//     Bench asserts it never happens; RTL ignores it (no reload).
//  Stall terms (combinational; x_match = WReg==field & field!=0 & use_x):
//   - LU (load-use): MemRead_id_ex & (rs or rt match on WReg_id_ex).
//   - BR (branch operand not ready): (Branch|jr|jalr) & any of:
//     (a) RegWrite_id_ex & rs match on WReg_id_ex;
//     (b) Branch & RegWrite_id_ex & rt match on WReg_id_ex;
//     (c) MemRead_ex_mem & rs match on WReg_ex_mem;
//     (d) Branch & MemRead_ex_mem & rt match on WReg_ex_mem.
//   - MD (HI/LO unit occupied): md_use_if_id & (md_busy | md_start_id_ex).
//   - stall = LU | BR | MD, and stall_if = stall_id = bubble_ex = stall.
//  stall_cycles increments on each clk edge where stall=1 and rst_n=1; it holds once saturated.
//  Register $0 never causes a stall. Simultaneous terms are OR'd and produce a single stall.
// TESTING
//  1. lw $3 in EX (MemRead_id_ex=1, WReg_id_ex=3); add rs=3 in ID -> stall=1 for 1 cycle; stall_cycles 0->1.
//  2. mult in EX with MULT_CYCLES=5; mflo in ID -> md_start pulse; md_busy=1 for cycles 1..5;
//     md_cnt 4,3,2,1,0; md_done at cycle 5; stall=1 in cycles 0..5; released at cycle 6.
//  3. div in EX with DIV_CYCLES=10 -> md_busy high 10 cycles; rst_n=0 at cycle 4
//     -> next cycle md_busy=0, md_cnt=0, no md_done.
//  4. beq rs=5, rt=6 in ID:
//     - EX writes $6 (RegWrite_id_ex=1) -> stall=1.
//     - Instead MEM load to $5 -> stall=1.
//     - Instead MEM ALU write to $5 (no MemRead) -> stall=0.
//  5. jr $0 while EX load targets $0 -> stall=0. jr rs=7 with EX writing $7 -> stall=1.
//  6. Force stall_cycles to 32'hFFFF_FFFE, then hold stall=1 for 3 cycles -> reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/md_stall_ctrl.sv
// Hazard/stall controller for the ID stage, plus the busy sequencer for the
// multi-cycle HI/LO mult/div unit and a saturating stall-cycle counter.
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_start_id_ex,
  input  logic             md_is_div,
  input  logic             md_use_if_id,
  input  logic             Branch,
  input  logic             jr,
  input  logic             jalr,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic             RegWrite_id_ex,
  input  logic             MemRead_id_ex,
  input  logic [4:0]       WReg_id_ex,
  input  logic             MemRead_ex_mem,
  input  logic [4:0]       WReg_ex_mem,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q;

  logic lu_stall, br_stall, md_stall, stall;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic is_ctrl_xfer;

  // Register $0 is hard-wired to zero, so it can never carry a hazard.
  function automatic logic reg_match(input logic [4:0] wreg,
                                     input logic [4:0] field,
                                     input logic       used);
    return used && (field != 5'd0) && (wreg == field);
  endfunction

  always_comb begin
    rs_ex  = reg_match(WReg_id_ex,  rs_if_id, use_rs_id);
    rt_ex  = reg_match(WReg_id_ex,  rt_if_id, use_rt_id);
    rs_mem = reg_match(WReg_ex_mem, rs_if_id, use_rs_id);
    rt_mem = reg_match(WReg_ex_mem, rt_if_id, use_rt_id);
  end

  // Branches compare rs/rt in ID; jr/jalr only read rs, hence the Branch gate on rt.
  assign is_ctrl_xfer = Branch | jr | jalr;
  assign lu_stall     = MemRead_id_ex & (rs_ex | rt_ex);
  assign br_stall     = is_ctrl_xfer & (
                          (RegWrite_id_ex & rs_ex)
                        | (Branch & RegWrite_id_ex & rt_ex)
                        | (MemRead_ex_mem & rs_mem)
                        | (Branch & MemRead_ex_mem & rt_mem));
  assign md_stall     = md_use_if_id & (md_busy | md_start_id_ex);
  assign stall        = lu_stall | br_stall | md_stall;

  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md_start_id_ex) begin
          md_start = 1'b1;
          state_d  = BUSY;
          cnt_d    = md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          md_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign md_busy      = (state_q == BUSY);
  assign md_cnt       = cnt_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Scoreboard bench for md_stall_ctrl: a cycle model pushes expected outputs
// per driven cycle, which are popped and compared against the DUT.
module tb_md_stall_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             md_start_id_ex, md_is_div, md_use_if_id;
  logic             Branch, jr, jalr, use_rs_id, use_rt_id;
  logic [4:0]       rs_if_id, rt_if_id, WReg_id_ex, WReg_ex_mem;
  logic             RegWrite_id_ex, MemRead_id_ex, MemRead_ex_mem;
  logic             stall_if, stall_id, bubble_ex, md_start, md_busy, md_done;
  logic [CNT_W-1:0] md_cnt;
  logic [31:0]      stall_cycles;

  md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .md_start_id_ex(md_start_id_ex), .md_is_div(md_is_div), .md_use_if_id(md_use_if_id),
    .Branch(Branch), .jr(jr), .jalr(jalr), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
    .RegWrite_id_ex(RegWrite_id_ex), .MemRead_id_ex(MemRead_id_ex), .WReg_id_ex(WReg_id_ex),
    .MemRead_ex_mem(MemRead_ex_mem), .WReg_ex_mem(WReg_ex_mem),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .md_cnt(md_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, start, is_div, md_use, br, jr, jalr, use_rs, use_rt;
    logic [4:0] rs, rt;
    logic       rw_ex, mr_ex;
    logic [4:0] wr_ex;
    logic       mr_mem;
    logic [4:0] wr_mem;
  } stim_t;

  typedef struct {
    logic        stall, start, busy, done;
    logic [31:0] cnt, cycles;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic        m_busy;
  int unsigned m_cnt;
  logic [31:0] m_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst_n: 1'b1, start: 1'b0, is_div: 1'b0, md_use: 1'b0, br: 1'b0, jr: 1'b0,
          jalr: 1'b0, use_rs: 1'b0, use_rt: 1'b0, rs: 5'd0, rt: 5'd0, rw_ex: 1'b0,
          mr_ex: 1'b0, wr_ex: 5'd0, mr_mem: 1'b0, wr_mem: 5'd0};
    return s;
  endfunction

  function automatic logic hit(input logic [4:0] w, input logic [4:0] f, input logic u);
    return u && f != 5'd0 && w == f;
  endfunction

  function automatic logic model_stall(input stim_t s);
    logic lu, br, md;
    lu = s.mr_ex && (hit(s.wr_ex, s.rs, s.use_rs) || hit(s.wr_ex, s.rt, s.use_rt));
    br = 1'b0;
    if (s.br || s.jr || s.jalr) begin
      if (s.rw_ex && hit(s.wr_ex, s.rs, s.use_rs))          br = 1'b1;
      if (s.br && s.rw_ex && hit(s.wr_ex, s.rt, s.use_rt))  br = 1'b1;
      if (s.mr_mem && hit(s.wr_mem, s.rs, s.use_rs))        br = 1'b1;
      if (s.br && s.mr_mem && hit(s.wr_mem, s.rt, s.use_rt)) br = 1'b1;
    end
    md = s.md_use && (m_busy || s.start);
    return lu || br || md;
  endfunction

  task automatic drive(input stim_t s);
    rst_n = s.rst_n; md_start_id_ex = s.start; md_is_div = s.is_div; md_use_if_id = s.md_use;
    Branch = s.br; jr = s.jr; jalr = s.jalr; use_rs_id = s.use_rs; use_rt_id = s.use_rt;
    rs_if_id = s.rs; rt_if_id = s.rt; RegWrite_id_ex = s.rw_ex; MemRead_id_ex = s.mr_ex;
    WReg_id_ex = s.wr_ex; MemRead_ex_mem = s.mr_mem; WReg_ex_mem = s.wr_mem;
  endtask

  // One clock cycle: drive at negedge, score combinational/registered outputs,
  // then advance the model to the state it will hold after the next posedge.
  task automatic step(input stim_t s);
    exp_t e, got;
    logic st;
    @(negedge clk);
    drive(s);
    st       = model_stall(s);
    e.stall  = st;
    e.start  = s.start && !m_busy;
    e.busy   = m_busy;
    e.done   = m_busy && m_cnt == 0;
    e.cnt    = m_cnt;
    e.cycles = m_cycles;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check("stall_if",     {31'd0, stall_if},  {31'd0, got.stall});
    check("stall_id",     {31'd0, stall_id},  {31'd0, got.stall});
    check("bubble_ex",    {31'd0, bubble_ex}, {31'd0, got.stall});
    check("md_start",     {31'd0, md_start},  {31'd0, got.start});
    check("md_busy",      {31'd0, md_busy},   {31'd0, got.busy});
    check("md_done",      {31'd0, md_done},   {31'd0, got.done});
    check("md_cnt",       {{(32-CNT_W){1'b0}}, md_cnt}, got.cnt);
    check("stall_cycles", stall_cycles, got.cycles);
    check("no_start_while_busy", {31'd0, md_start_id_ex && md_busy}, 32'd0);
    if (!s.rst_n) begin
      m_busy = 1'b0; m_cnt = 0; m_cycles = 32'd0;
    end else begin
      if (st && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
      if (!m_busy && s.start) begin
        m_busy = 1'b1;
        m_cnt  = s.is_div ? 9 : 4;
      end else if (m_busy) begin
        if (m_cnt == 0) m_busy = 1'b0;
        else            m_cnt  = m_cnt - 1;
      end
    end
  endtask

  initial begin
    stim_t s;
    drive(idle_stim());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    m_busy = 1'b0; m_cnt = 0; m_cycles = 32'd0;

    // Post-reset idle state
    step(idle_stim());

    // Load-use on rs
    s = idle_stim(); s.mr_ex = 1'b1; s.rw_ex = 1'b1; s.wr_ex = 5'd3; s.use_rs = 1'b1; s.rs = 5'd3;
    step(s);
    step(idle_stim());

    // mult then mflo held in ID until released
    s = idle_stim(); s.start = 1'b1; s.md_use = 1'b1;
    step(s);
    s = idle_stim(); s.md_use = 1'b1;
    repeat (6) step(s);
    step(idle_stim());

    // div abandoned by reset mid-operation
    s = idle_stim(); s.start = 1'b1; s.is_div = 1'b1;
    step(s);
    repeat (3) step(idle_stim());
    s = idle_stim(); s.rst_n = 1'b0;
    step(s);
    repeat (2) step(idle_stim());

    // beq rs=5 rt=6
    s = idle_stim(); s.br = 1'b1; s.use_rs = 1'b1; s.use_rt = 1'b1; s.rs = 5'd5; s.rt = 5'd6;
    s.rw_ex = 1'b1; s.wr_ex = 5'd6;
    step(s);
    s.rw_ex = 1'b0; s.wr_ex = 5'd0; s.mr_mem = 1'b1; s.wr_mem = 5'd5;
    step(s);
    s.mr_mem = 1'b0;
    step(s);

    // jr $0 against EX load to $0, then jr $7 against EX write to $7
    s = idle_stim(); s.jr = 1'b1; s.use_rs = 1'b1; s.rs = 5'd0; s.mr_ex = 1'b1; s.wr_ex = 5'd0;
    step(s);
    s.mr_ex = 1'b0; s.rw_ex = 1'b1; s.rs = 5'd7; s.wr_ex = 5'd7;
    step(s);
    // jalr ignores rt even when it matches
    s = idle_stim(); s.jalr = 1'b1; s.use_rt = 1'b1; s.rt = 5'd9; s.rw_ex = 1'b1; s.wr_ex = 5'd9;
    step(s);

    // Randomised mix; start is only offered while the model says the unit is idle
    for (int i = 0; i < 60; i++) begin
      s = idle_stim();
      s.start  = !m_busy && ($urandom_range(0, 3) == 0);
      s.is_div = 1'($urandom_range(0, 1));
      s.md_use = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 2) == 0);
      s.jr     = ($urandom_range(0, 4) == 0);
      s.jalr   = ($urandom_range(0, 4) == 0);
      s.use_rs = 1'($urandom_range(0, 1));
      s.use_rt = 1'($urandom_range(0, 1));
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.rw_ex  = 1'($urandom_range(0, 1));
      s.mr_ex  = 1'($urandom_range(0, 1));
      s.wr_ex  = 5'($urandom_range(0, 3));
      s.mr_mem = 1'($urandom_range(0, 1));
      s.wr_mem = 5'($urandom_range(0, 3));
      step(s);
    end
    while (m_busy) step(idle_stim());

    // Saturation of the stall counter
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cycles = 32'hFFFF_FFFE;
    s = idle_stim(); s.mr_ex = 1'b1; s.wr_ex = 5'd4; s.use_rt = 1'b1; s.rt = 5'd4;
    repeat (3) step(s);
    step(idle_stim());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
